// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage target for load/store requests. Holds stall
// while an access is in flight, completes it against a register-based word
// array after LATENCY cycles and returns load data with a one-cycle done pulse.
module data_mem_responder #(
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_LENGTH = 8,
    parameter int DEPTH       = 128,
    parameter int LATENCY     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_LENGTH-1:0] address,
    input  logic [WORD_LENGTH-1:0] write_data,
    output logic [WORD_LENGTH-1:0] read_data,
    output logic                   done,
    output logic                   stall,
    output logic                   error
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_LENGTH:0] DEPTH_W = (ADDR_LENGTH + 1)'(DEPTH);
    // The IDLE cycle counts as the first latency cycle, so WAIT spans
    // LATENCY-1 cycles and the count loaded on entry is LATENCY-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [WORD_LENGTH-1:0] read_data_q, read_data_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [WORD_LENGTH-1:0] mem_q [DEPTH];

    logic                   commit;
    logic                   c_wr;
    logic [ADDR_LENGTH-1:0] c_addr;
    logic [WORD_LENGTH-1:0] c_data;
    logic                   c_in_range;
    logic                   req;

    function automatic logic in_range(input logic [ADDR_LENGTH-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    assign req        = mem_read | mem_write;
    assign c_in_range = in_range(c_addr);

    // Next-state, request latching, commit selection and stall generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        stall       = 1'b0;
        commit      = 1'b0;
        c_wr        = op_wr_q;
        c_addr      = addr_q;
        c_data      = data_q;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    op_wr_d = mem_write;
                    addr_d  = address;
                    data_d  = write_data;
                    if ((mem_read && mem_write) || !in_range(address)) begin
                        error_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits straight from the inputs.
                        commit  = 1'b1;
                        c_wr    = mem_write;
                        c_addr  = address;
                        c_data  = write_data;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit) begin
            done_d = 1'b1;
            if (!c_wr) begin
                read_data_d = c_in_range ? mem_q[c_addr[IDX_W-1:0]] : '0;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Word array; out-of-range stores are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else if (commit && c_wr && c_in_range) begin
            mem_q[c_addr[IDX_W-1:0]] <= c_data;
        end
    end

    assign read_data = read_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=3 (A), one at LATENCY=1 (B).
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rd_a, wr_a, rd_b, wr_b;
    logic [7:0] addr_a, wd_a, addr_b, wd_b;
    logic [7:0] rdata_a, rdata_b;
    logic       done_a, stall_a, err_a, done_b, stall_b, err_b;

    data_mem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .DEPTH(128), .LATENCY(3)) u_dut_a (
        .clk(clk), .rst(rst_n), .mem_read(rd_a), .mem_write(wr_a), .address(addr_a),
        .write_data(wd_a), .read_data(rdata_a), .done(done_a), .stall(stall_a), .error(err_a));

    data_mem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .DEPTH(128), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst_n), .mem_read(rd_b), .mem_write(wr_b), .address(addr_b),
        .write_data(wd_b), .read_data(rdata_b), .done(done_b), .stall(stall_b), .error(err_b));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mdl_a [256];
    logic [7:0] mdl_b [256];
    logic [7:0] last_a, last_b;
    logic       experr_a, experr_b;
    logic [7:0] sb_q [$];

    task automatic drive(input logic sel, input logic rd, input logic wr,
                         input logic [7:0] ad, input logic [7:0] wd);
        if (sel) begin
            rd_b = rd; wr_b = wr; addr_b = ad; wd_b = wd;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = ad; wd_a = wd;
        end
    endtask

    task automatic sample(input logic sel, output logic st, output logic dn,
                          output logic er, output logic [7:0] rv);
        st = sel ? stall_b : stall_a;
        dn = sel ? done_b  : done_a;
        er = sel ? err_b   : err_a;
        rv = sel ? rdata_b : rdata_a;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            mdl_a[i] = 8'h00;
            mdl_b[i] = 8'h00;
        end
        last_a = 8'h00; last_b = 8'h00;
        experr_a = 1'b0; experr_b = 1'b0;
        sb_q.delete();
    endtask

    // One access: starts at the next falling edge, returns in the done cycle.
    task automatic xact(input logic sel, input logic rd, input logic wr,
                        input logic [7:0] ad, input logic [7:0] wd, input string name);
        int lat = sel ? 1 : 3;
        int c;
        bit seen;
        logic st, dn, er;
        logic [7:0] rv, exp_v, last_v;
        logic in_r;
        in_r = (ad < 8'd128);
        @(negedge clk);
        if ((rd && wr) || !in_r) begin
            if (sel) experr_b = 1'b1; else experr_a = 1'b1;
        end
        if (wr) begin
            if (in_r) begin
                if (sel) mdl_b[ad] = wd; else mdl_a[ad] = wd;
            end
        end else if (rd) begin
            sb_q.push_back(!in_r ? 8'h00 : (sel ? mdl_b[ad] : mdl_a[ad]));
        end
        drive(sel, rd, wr, ad, wd);
        #1;
        sample(sel, st, dn, er, rv);
        n_checks++;
        if (st !== 1'b1 || dn !== 1'b0) begin
            n_errors++;
            $display("FAIL %s cycle0 stall/done got %b/%b exp 1/0", name, st, dn);
        end
        seen = 0;
        for (c = 1; c <= lat + 3 && !seen; c++) begin
            @(negedge clk);
            #1;
            sample(sel, st, dn, er, rv);
            if (dn === 1'b1) begin
                seen = 1;
                last_done_cyc = cyc;
                n_checks++;
                if (c != lat || st !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s done cycle/stall got %0d/%b exp %0d/0", name, c, st, lat);
                end
                last_v = sel ? last_b : last_a;
                if (rd && !wr) begin
                    exp_v = sb_q.pop_front();
                    if (sel) last_b = exp_v; else last_a = exp_v;
                end else begin
                    exp_v = last_v;
                end
                n_checks++;
                if (rv !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s read_data got %h exp %h", name, rv, exp_v);
                end
                n_checks++;
                if (er !== (sel ? experr_b : experr_a)) begin
                    n_errors++;
                    $display("FAIL %s error got %b exp %b", name, er, sel ? experr_b : experr_a);
                end
            end else if (c < lat) begin
                n_checks++;
                if (st !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s stall cycle%0d got %b exp 1", name, c, st);
                end
            end
        end
        if (!seen) begin
            n_errors++;
            $display("FAIL %s done timeout got 0 exp 1 within %0d cycles", name, lat + 3);
        end
        drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic idle_check(input logic sel, input string name);
        logic st, dn, er;
        logic [7:0] rv;
        @(negedge clk);
        #1;
        sample(sel, st, dn, er, rv);
        n_checks++;
        if (st !== 1'b0 || dn !== 1'b0 || rv !== (sel ? last_b : last_a)) begin
            n_errors++;
            $display("FAIL %s idle stall/done/rdata got %b/%b/%h exp 0/0/%h",
                     name, st, dn, rv, sel ? last_b : last_a);
        end
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        clear_models();
        n_checks++;
        if ({rdata_a, done_a, stall_a, err_a, rdata_b, done_b, stall_b, err_b} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got A %h/%b/%b/%b B %h/%b/%b/%b exp all 0",
                     rdata_a, done_a, stall_a, err_a, rdata_b, done_b, stall_b, err_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        xact(1'b0, 1'b0, 1'b1, 8'h05, 8'h99, "pre_reset_wr5");
        apply_reset();
        xact(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, "reset_rd5");
    endtask

    task automatic test_write_read();
        xact(1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, "wr10");
        xact(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, "rd10");
        idle_check(1'b0, "hold_a5_0");
        idle_check(1'b0, "hold_a5_1");
        xact(1'b0, 1'b0, 1'b1, 8'h11, 8'h5A, "wr11");
        idle_check(1'b0, "hold_after_wr");
    endtask

    task automatic test_latency1();
        int start;
        xact(1'b1, 1'b0, 1'b1, 8'h01, 8'h11, "l1_wr01");
        xact(1'b1, 1'b0, 1'b1, 8'h02, 8'h22, "l1_wr02");
        idle_check(1'b1, "l1_idle");
        start = cyc + 1;
        xact(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, "l1_rd01");
        n_checks++;
        if (last_done_cyc != start + 1) begin
            n_errors++;
            $display("FAIL l1_b2b_first done cycle got %0d exp %0d", last_done_cyc - start, 1);
        end
        xact(1'b1, 1'b1, 1'b0, 8'h02, 8'h00, "l1_rd02");
        n_checks++;
        if (last_done_cyc != start + 3) begin
            n_errors++;
            $display("FAIL l1_b2b_second done cycle got %0d exp %0d", last_done_cyc - start, 3);
        end
    endtask

    task automatic test_simultaneous();
        xact(1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, "rdwr20");
        xact(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "rd20");
        idle_check(1'b0, "rdwr_idle");
    endtask

    task automatic test_out_of_range();
        apply_reset();
        xact(1'b0, 1'b0, 1'b1, 8'h80, 8'h77, "oor_wr80");
        xact(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "oor_rd00");
        xact(1'b0, 1'b0, 1'b1, 8'h7F, 8'hE1, "edge_wr7f");
        xact(1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, "edge_rd7f");
        xact(1'b0, 1'b1, 1'b0, 8'h80, 8'h00, "oor_rd80");
    endtask

    task automatic test_reset_wait();
        apply_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 8'h04, 8'h55);
        @(negedge clk);
        #2;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (stall_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_wait stall/done/error got %b/%b/%b exp 0/0/0", stall_a, done_a, err_a);
        end
        clear_models();
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, "rst_wait_rd04");
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        clear_models();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_latency1();
        test_simultaneous();
        test_out_of_range();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
